puf_race_evaluator: RTL and testbench

Control and decision block on the consuming side of the two post-mux ring-oscillator counters. It drives the counters' clear and enable lines for each challenge, watches their `finished` flags to decide which oscillator won the race, and packs R decided bits into a response word. The word is offered to downstream logic (serializer/UART) over a valid/ready handshake.

---
 rtl/puf_race_evaluator_if.sv | 47 ++++
 rtl/puf_race_evaluator.sv | 201 ++++++++++++++++++++
 tb/tb_puf_race_evaluator.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_race_evaluator_if.sv
// Bundles the oscillator-counter control lines and the response handshake of the
// PUF race evaluator. The evaluator uses the master side. The counters and the
// downstream consumer use the slave side.
interface puf_race_evaluator_if #(
    parameter int R  = 8,
    parameter int IW = (R > 1) ? $clog2(R) : 1
);
    // Counter side: mux select, clear/enable, and the sticky finished flags.
    logic [IW-1:0] chal_idx;
    logic          ctr_clr;
    logic          ctr_en;
    logic          fin_a;
    logic          fin_b;

    // Response side: packed decision word plus sticky quality flags.
    logic [R-1:0]  resp;
    logic          resp_valid;
    logic          resp_ready;
    logic          tie_seen;
    logic          timeout_err;

    modport master (
        output chal_idx,
        output ctr_clr,
        output ctr_en,
        input  fin_a,
        input  fin_b,
        output resp,
        output resp_valid,
        input  resp_ready,
        output tie_seen,
        output timeout_err
    );

    modport slave (
        input  chal_idx,
        input  ctr_clr,
        input  ctr_en,
        output fin_a,
        output fin_b,
        input  resp,
        input  resp_valid,
        output resp_ready,
        input  tie_seen,
        input  timeout_err
    );
endinterface

// File: rtl/puf_race_evaluator.sv
// PUF race evaluator.
// For each challenge index the evaluator does four things:
//   1. It clears both post-mux ring-oscillator counters.
//   2. It lets them race.
//   3. It decides the winner from their finished flags.
//   4. It stores the resulting bit.
// After R bits it offers the packed word over a valid/ready handshake.
// Every output is a flop, so the counter controls never glitch.
module puf_race_evaluator #(
    parameter int N       = 23,
    parameter int R       = 8,
    parameter int TIMEOUT = 33554432
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    puf_race_evaluator_if.master  bus
);

    localparam int              IW         = (R > 1) ? $clog2(R) : 1;
    localparam logic [31:0]     TIMER_LAST = 32'(TIMEOUT - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(R - 1);

    // A race needs at least one cycle.
    // A word needs at least two bits for the index to mean anything.
    // The counters need at least two bits.
    if (N < 2 || R < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("puf_race_evaluator: N >= 2, R >= 2 and TIMEOUT >= 1 are required");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t        state_q,    state_d;
    logic          clr_cnt_q,  clr_cnt_d;
    logic [31:0]   timer_q,    timer_d;
    logic [IW-1:0] chal_idx_q, chal_idx_d;
    logic [R-1:0]  resp_q,     resp_d;
    logic          bit_q,      bit_d;
    logic          tie_q,      tie_d;
    logic          to_q,       to_d;
    logic          valid_q,    valid_d;
    logic          busy_q,     busy_d;
    logic          ctr_clr_q,  ctr_clr_d;
    logic          ctr_en_q,   ctr_en_d;

    logic          dec_hit;
    logic          dec_bit;
    logic          dec_tie;
    logic          dec_to;

    // Race decision for the current RUN cycle.
    // A finished flag always beats the timeout, even when both land in the last
    // cycle. A simultaneous finish is a tie and is resolved to 0.
    always_comb begin
        dec_hit = 1'b0;
        dec_bit = 1'b0;
        dec_tie = 1'b0;
        dec_to  = 1'b0;
        if (bus.fin_a && !bus.fin_b) begin
            dec_hit = 1'b1;
            dec_bit = 1'b1;
        end else if (bus.fin_b && !bus.fin_a) begin
            dec_hit = 1'b1;
        end else if (bus.fin_a && bus.fin_b) begin
            dec_hit = 1'b1;
            dec_tie = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
            dec_hit = 1'b1;
            dec_to  = 1'b1;
        end
    end

    // Next-state and datapath logic.
    // The output decodes are taken from the next state, so the registered
    // outputs line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        timer_d    = timer_q;
        chal_idx_d = chal_idx_q;
        resp_d     = resp_q;
        bit_d      = bit_q;
        tie_d      = tie_q;
        to_d       = to_q;
        valid_d    = valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    clr_cnt_d  = 1'b0;
                    chal_idx_d = '0;
                    resp_d     = '0;
                    tie_d      = 1'b0;
                    to_d       = 1'b0;
                end
            end

            S_CLEAR: begin
                timer_d = '0;
                if (clr_cnt_q) begin
                    state_d = S_RUN;
                end else begin
                    clr_cnt_d = 1'b1;
                end
            end

            S_RUN: begin
                timer_d = timer_q + 32'd1;
                if (dec_hit) begin
                    state_d = S_CAPTURE;
                    bit_d   = dec_bit;
                    if (dec_tie) begin
                        tie_d = 1'b1;
                    end
                    if (dec_to) begin
                        to_d = 1'b1;
                    end
                end
            end

            S_CAPTURE: begin
                resp_d[chal_idx_q] = bit_q;
                if (chal_idx_q == IDX_LAST) begin
                    state_d = S_HOLD;
                    valid_d = 1'b1;
                end else begin
                    chal_idx_d = chal_idx_q + IW'(1);
                    clr_cnt_d  = 1'b0;
                    state_d    = S_CLEAR;
                end
            end

            S_HOLD: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        ctr_clr_d = (state_d != S_RUN);
        ctr_en_d  = (state_d == S_RUN);
    end

    // State and output registers.
    // Reset drops everything at once, so the counters stay cleared and no
    // partial word escapes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            clr_cnt_q  <= 1'b0;
            timer_q    <= '0;
            chal_idx_q <= '0;
            resp_q     <= '0;
            bit_q      <= 1'b0;
            tie_q      <= 1'b0;
            to_q       <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ctr_clr_q  <= 1'b1;
            ctr_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            timer_q    <= timer_d;
            chal_idx_q <= chal_idx_d;
            resp_q     <= resp_d;
            bit_q      <= bit_d;
            tie_q      <= tie_d;
            to_q       <= to_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            ctr_clr_q  <= ctr_clr_d;
            ctr_en_q   <= ctr_en_d;
        end
    end

    assign busy            = busy_q;
    assign bus.chal_idx    = chal_idx_q;
    assign bus.ctr_clr     = ctr_clr_q;
    assign bus.ctr_en      = ctr_en_q;
    assign bus.resp        = resp_q;
    assign bus.resp_valid  = valid_q;
    assign bus.tie_seen    = tie_q;
    assign bus.timeout_err = to_q;

endmodule

// File: tb/tb_puf_race_evaluator.sv
// Self-checking bench for puf_race_evaluator (R=8, TIMEOUT=16).
// Each challenge gets a planned RUN cycle at which counter A and counter B
// finish (0 means never). The bench drives the finished flags from that plan.
// A plan-level race model predicts the word, the flags and the latency.
module tb_puf_race_evaluator;

    localparam int R       = 8;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000000;

    logic clk;
    logic reset;
    logic start;
    logic busy;

    puf_race_evaluator_if #(.R(R)) bus ();

    puf_race_evaluator #(.N(23), .R(R), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cur_pa [R];
    int cur_pb [R];
    int run_k  = 0;

    typedef struct packed {
        logic [R-1:0][7:0] pa;
        logic [R-1:0][7:0] pb;
        logic [R-1:0]      resp;
        logic              tie;
        logic              to;
        logic [15:0]       lat;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock edge, then model the counters.
    // A flag rises once the current RUN cycle reaches its plan, and stays high until the clear.
    task automatic tick();
        int idx;
        @(posedge clk);
        #1;
        if (bus.ctr_en) run_k++;
        else            run_k = 0;
        idx = int'(bus.chal_idx);
        bus.fin_a = bus.ctr_en && cur_pa[idx] != 0 && run_k >= cur_pa[idx];
        bus.fin_b = bus.ctr_en && cur_pb[idx] != 0 && run_k >= cur_pb[idx];
    endtask

    // Race model working from the plan.
    // The earliest finish or the timeout ends the race.
    // Counter A alone finishing at that moment gives bit 1.
    function automatic void model(output logic [R-1:0] r, output logic tie, output logic to, output int lat);
        int ta, tb, t;
        r = '0; tie = 1'b0; to = 1'b0; lat = 0;
        for (int i = 0; i < R; i++) begin
            ta = (cur_pa[i] == 0) ? NEVER : cur_pa[i];
            tb = (cur_pb[i] == 0) ? NEVER : cur_pb[i];
            t  = TIMEOUT;
            if (ta < t) t = ta;
            if (tb < t) t = tb;
            r[i] = (ta == t) && (tb != t);
            if (ta == t && tb == t) tie = 1'b1;
            if (ta != t && tb != t) to = 1'b1;
            lat += 3 + t;
        end
    endfunction

    // Pulse start and follow the word until resp_valid rises.
    // Between races the bench also checks three things:
    //   - the gap with counters cleared (2 cycles first, then CAPTURE plus 2 CLEAR);
    //   - clr/en exclusivity;
    //   - the chal_idx stepping.
    task automatic applyStimulus(output int lat, output logic seq_ok, output int races);
        int gap;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; gap = 1; races = 0; seq_ok = 1'b1;
        while (!bus.resp_valid && lat < 2000) begin
            tick();
            lat++;
            if (bus.ctr_en) begin
                if (bus.ctr_clr) seq_ok = 1'b0;
                if (gap != 0) begin
                    if (gap != ((races == 0) ? 2 : 3)) seq_ok = 1'b0;
                    if (int'(bus.chal_idx) != races) seq_ok = 1'b0;
                    races++;
                    gap = 0;
                end
            end else begin
                if (!bus.ctr_clr && busy) seq_ok = 1'b0;
                gap++;
            end
        end
        checkOutput("resp_valid_rises", {31'd0, bus.resp_valid}, 32'd1);
    endtask

    // Complete the handshake and confirm the return to IDLE with resp retained.
    task automatic releaseWord(input logic [R-1:0] exp_resp);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_valid", {31'd0, bus.resp_valid}, 32'd0);
        checkOutput("idle_resp_kept", 32'(bus.resp), 32'(exp_resp));
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int          lat, races;
        logic        seq_ok, stable;
        logic [R-1:0] m_resp, r0;
        logic        m_tie, m_to;
        int          m_lat;

        reset = 1'b0; start = 1'b0;
        bus.fin_a = 1'b0; bus.fin_b = 1'b0; bus.resp_ready = 1'b0;
        for (int i = 0; i < R; i++) begin cur_pa[i] = 0; cur_pb[i] = 0; end

        #12;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_chal_idx", 32'(bus.chal_idx), 32'd0);
        checkOutput("rst_ctr_clr", {31'd0, bus.ctr_clr}, 32'd1);
        checkOutput("rst_ctr_en", {31'd0, bus.ctr_en}, 32'd0);
        checkOutput("rst_resp", 32'(bus.resp), 32'd0);
        checkOutput("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
        checkOutput("rst_tie", {31'd0, bus.tie_seen}, 32'd0);
        checkOutput("rst_to", {31'd0, bus.timeout_err}, 32'd0);
        reset = 1'b1;
        tick();

        // Directed vectors, with expected values written by hand.
        for (int i = 0; i < R; i++) begin
            vecs[0].pa[i] = 8'd10; vecs[0].pb[i] = 8'd0;
            vecs[1].pa[i] = (i % 2 == 1) ? 8'd5 : 8'd0;
            vecs[1].pb[i] = (i % 2 == 0) ? 8'd5 : 8'd0;
            vecs[2].pa[i] = (i == 3) ? 8'd7 : 8'd10;
            vecs[2].pb[i] = (i == 3) ? 8'd7 : 8'd0;
            vecs[3].pa[i] = (i == 0) ? 8'd0 : 8'd10; vecs[3].pb[i] = 8'd0;
            vecs[4].pa[i] = (i == 0) ? 8'd16 : 8'd10; vecs[4].pb[i] = 8'd0;
        end
        vecs[0].resp = 8'hFF; vecs[0].tie = 1'b0; vecs[0].to = 1'b0; vecs[0].lat = 16'd104;
        vecs[1].resp = 8'hAA; vecs[1].tie = 1'b0; vecs[1].to = 1'b0; vecs[1].lat = 16'd64;
        vecs[2].resp = 8'hF7; vecs[2].tie = 1'b1; vecs[2].to = 1'b0; vecs[2].lat = 16'd101;
        vecs[3].resp = 8'hFE; vecs[3].tie = 1'b0; vecs[3].to = 1'b1; vecs[3].lat = 16'd110;
        vecs[4].resp = 8'hFF; vecs[4].tie = 1'b0; vecs[4].to = 1'b0; vecs[4].lat = 16'd110;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < R; i++) begin
                cur_pa[i] = int'(vecs[v].pa[i]);
                cur_pb[i] = int'(vecs[v].pb[i]);
            end
            applyStimulus(lat, seq_ok, races);
            checkOutput($sformatf("vec%0d_resp", v), 32'(bus.resp), 32'(vecs[v].resp));
            checkOutput($sformatf("vec%0d_tie", v), {31'd0, bus.tie_seen}, {31'd0, vecs[v].tie});
            checkOutput($sformatf("vec%0d_timeout", v), {31'd0, bus.timeout_err}, {31'd0, vecs[v].to});
            checkOutput($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            checkOutput($sformatf("vec%0d_sequence", v), {31'd0, seq_ok}, 32'd1);
            checkOutput($sformatf("vec%0d_races", v), 32'(races), 32'(R));
            releaseWord(vecs[v].resp);
        end

        // Backpressure in HOLD.
        // resp must stay put, and start pulses must be ignored.
        for (int i = 0; i < R; i++) begin cur_pa[i] = 5; cur_pb[i] = (i == 2) ? 3 : 0; end
        applyStimulus(lat, seq_ok, races);
        r0 = bus.resp;
        checkOutput("hold_resp", 32'(r0), 32'h00FB);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5 || i == 12) ? 1'b1 : 1'b0;
            tick();
            if (!bus.resp_valid || bus.resp !== r0 || !busy || bus.ctr_en) stable = 1'b0;
        end
        start = 1'b0;
        checkOutput("hold_stable", {31'd0, stable}, 32'd1);
        releaseWord(8'hFB);
        tick();
        checkOutput("no_queued_start", {31'd0, busy}, 32'd0);

        // Reset asserted in the middle of RUN for index 4.
        for (int i = 0; i < R; i++) begin cur_pa[i] = 10; cur_pb[i] = 0; end
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!(bus.ctr_en && bus.chal_idx == 3'd4) && lat < 500) begin tick(); lat++; end
        checkOutput("reached_idx4_run", {31'd0, bus.ctr_en}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_ctr_clr", {31'd0, bus.ctr_clr}, 32'd1);
        checkOutput("mid_rst_ctr_en", {31'd0, bus.ctr_en}, 32'd0);
        checkOutput("mid_rst_chal_idx", 32'(bus.chal_idx), 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_valid", {31'd0, bus.resp_valid}, 32'd0);
        bus.fin_a = 1'b0; bus.fin_b = 1'b0; run_k = 0;
        #3;
        reset = 1'b1;
        applyStimulus(lat, seq_ok, races);
        checkOutput("post_rst_resp", 32'(bus.resp), 32'h00FF);
        checkOutput("post_rst_latency", 32'(lat), 32'd104);
        releaseWord(8'hFF);

        // Randomized plans, checked against the race model.
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < R; i++) begin
                cur_pa[i] = int'($urandom_range(0, 20));
                cur_pb[i] = ($urandom_range(0, 3) == 0) ? cur_pa[i] : int'($urandom_range(0, 20));
            end
            model(m_resp, m_tie, m_to, m_lat);
            applyStimulus(lat, seq_ok, races);
            checkOutput($sformatf("rnd%0d_resp", w), 32'(bus.resp), 32'(m_resp));
            checkOutput($sformatf("rnd%0d_tie", w), {31'd0, bus.tie_seen}, {31'd0, m_tie});
            checkOutput($sformatf("rnd%0d_timeout", w), {31'd0, bus.timeout_err}, {31'd0, m_to});
            checkOutput($sformatf("rnd%0d_latency", w), 32'(lat), 32'(m_lat));
            checkOutput($sformatf("rnd%0d_sequence", w), {31'd0, seq_ok}, 32'd1);
            releaseWord(m_resp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
